// File: rtl/green_led_sequencer.sv
// Green LED sequencer: a small config slave plus an Avalon-MM master that
// writes static, blinking or rotating patterns into the LED PIO data register.
module green_led_sequencer #(
  parameter int WIDTH          = 9,
  parameter int CNT_W          = 24,
  parameter int DEFAULT_PERIOD = 5000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic             pio_chipselect,
  output logic             pio_write_n,
  output logic [1:0]       pio_address,
  output logic [WIDTH-1:0] pio_writedata
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } state_t;

  localparam logic [1:0] MODE_BLINK = 2'd1;
  localparam logic [1:0] MODE_ROTL  = 2'd2;
  localparam logic [1:0] MODE_ROTR  = 2'd3;

  // configuration and sequencing state
  logic             r_en;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_pattern;
  logic [CNT_W-1:0] r_period;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_frame;
  state_t           r_state;

  // combinational helpers
  state_t           w_state_next;
  logic             w_cfg_wr;
  logic             w_wr_ctrl;
  logic             w_wr_pattern;
  logic             w_wr_period;
  logic             w_new_en;
  logic [CNT_W-1:0] w_last;
  logic             w_tick;
  logic [CNT_W-1:0] w_cnt_next;
  logic [WIDTH-1:0] w_frame_next;
  logic             w_update;
  logic             w_unused;

  assign w_cfg_wr     = chipselect && !write_n;
  assign w_wr_ctrl    = w_cfg_wr && (address == 2'd0);
  assign w_wr_pattern = w_cfg_wr && (address == 2'd1);
  assign w_wr_period  = w_cfg_wr && (address == 2'd2);
  assign w_new_en     = writedata[0];

  // PERIOD of 0 behaves like 1: the tick fires every cycle
  assign w_last = (r_period == '0) ? '0 : (r_period - 1'b1);
  assign w_tick = r_en && (r_cnt == w_last);

  assign pio_address = 2'b00;
  assign w_unused    = &{1'b0, writedata[31:CNT_W]};

  // config register writes; FRAME (addr3) is read-only
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en      <= 1'b0;
      r_mode    <= 2'd0;
      r_pattern <= '0;
      r_period  <= CNT_W'(DEFAULT_PERIOD);
    end else begin
      if (w_wr_ctrl) begin
        r_en   <= w_new_en;
        r_mode <= writedata[2:1];
      end
      if (w_wr_pattern) begin
        r_pattern <= writedata[WIDTH-1:0];
      end
      if (w_wr_period) begin
        r_period <= writedata[CNT_W-1:0];
      end
    end
  end

  // next prescaler count and frame; a config write overrides a coincident tick
  always_comb begin
    w_cnt_next   = r_cnt;
    w_frame_next = r_frame;
    w_update     = 1'b0;
    if (w_wr_ctrl) begin
      w_cnt_next = '0;
      if (w_new_en) begin
        w_frame_next = r_pattern;
        w_update     = 1'b1;
      end else if (r_en) begin
        w_frame_next = '0;
        w_update     = 1'b1;
      end
    end else if (w_wr_pattern) begin
      w_cnt_next = '0;
      if (r_en) begin
        w_frame_next = writedata[WIDTH-1:0];
        w_update     = 1'b1;
      end
    end else if (w_wr_period) begin
      w_cnt_next = '0;
    end else if (!r_en) begin
      w_cnt_next = '0;
    end else if (w_tick) begin
      w_cnt_next = '0;
      case (r_mode)
        MODE_BLINK: begin
          w_frame_next = (r_frame == '0) ? r_pattern : '0;
          w_update     = 1'b1;
        end
        MODE_ROTL: begin
          w_frame_next = {r_frame[WIDTH-2:0], r_frame[WIDTH-1]};
          w_update     = 1'b1;
        end
        MODE_ROTR: begin
          w_frame_next = {r_frame[0], r_frame[WIDTH-1:1]};
          w_update     = 1'b1;
        end
        default: ;
      endcase
    end else begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  // prescaler and frame registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt   <= '0;
      r_frame <= '0;
    end else begin
      r_cnt   <= w_cnt_next;
      r_frame <= w_frame_next;
    end
  end

  // write FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // write FSM next state and PIO strobes; one write per frame update
  always_comb begin
    w_state_next   = S_IDLE;
    pio_chipselect = 1'b0;
    pio_write_n    = 1'b1;
    pio_writedata  = '0;
    if (w_update) begin
      w_state_next = S_WRITE;
    end
    case (r_state)
      S_WRITE: begin
        pio_chipselect = 1'b1;
        pio_write_n    = 1'b0;
        pio_writedata  = r_frame;
      end
      default: ;
    endcase
  end

  // config read mux, zero-extended
  always_comb begin
    readdata = '0;
    case (address)
      2'd0: begin
        readdata[0]   = r_en;
        readdata[2:1] = r_mode;
      end
      2'd1: readdata[WIDTH-1:0] = r_pattern;
      2'd2: readdata[CNT_W-1:0] = r_period;
      default: readdata[WIDTH-1:0] = r_frame;
    endcase
  end

endmodule
